// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg -- shared definitions for the pipeline control block.
//   state_e            : FSM state encodings (RUN=0, FLUSH=1, STALL=2; 3 is illegal)
//   FLUSH_LEN_DEF      : default number of flush cycles per taken jump
//   STALL_TIMEOUT_DEF  : default consecutive stall cycles before timeout
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_STALL = 2'd2
  } state_e;

  localparam int unsigned FLUSH_LEN_DEF     = 2;
  localparam logic [15:0] STALL_TIMEOUT_DEF = 16'd1000;

endpackage

// File: rtl/pipe_ctrl_perf.sv
// pipe_ctrl_perf -- free-running performance counters for pipe_ctrl.
// Only instantiated when PIPE_CTRL_PERF_EN is defined.
//   clk, rst      : clock, synchronous active-high reset
//   stall_inc     : count one stall cycle this clock
//   flush_inc     : count one flush event this clock
//   stall_cycles  : 32-bit wrapping count of stall cycles
//   flush_events  : 32-bit wrapping count of flush events
module pipe_ctrl_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_inc,
  input  logic        flush_inc,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);

  // Counters wrap naturally at 32'hffff_ffff -> 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall_inc) stall_cycles <= stall_cycles + 32'd1;
      if (flush_inc) flush_events <= flush_events + 32'd1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline hazard controller: jump redirect/flush, stall holds,
// and a sticky stall-timeout flag.
// Optional feature macro: PIPE_CTRL_PERF_EN (adds stall/flush perf counters;
// when undefined the counter ports are tied to zero).
//   clk, rst        : clock, synchronous active-high reset
//   jump_en_i/addr  : taken branch/JAL and target from execute
//   hold_flag_ex_i  : execute needs another cycle
//   hold_req_bus_i  : fetch bus not ready
//   jump_en_o/addr  : redirect request and target to the PC register
//   hold_pc_o, hold_if_id_o, hold_id_ex_o : pipeline register holds
//   flush_o         : IF/ID and ID/EX load NOP
//   timeout_o       : sticky stall-timeout flag
//   state_o         : current FSM state (debug)
//   stall_cycles_o, flush_events_o : perf counters (zero unless enabled)
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_LEN     = FLUSH_LEN_DEF,
  parameter logic [15:0] STALL_TIMEOUT = STALL_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_ex_i,
  input  logic        hold_req_bus_i,
  output logic        jump_en_o,
  output logic [31:0] jump_addr_o,
  output logic        hold_pc_o,
  output logic        hold_if_id_o,
  output logic        hold_id_ex_o,
  output logic        flush_o,
  output logic        timeout_o,
  output logic [1:0]  state_o,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flush_events_o
);

  // The jump cycle itself is the first flush cycle, so FLUSH holds FLUSH_LEN-1 cycles.
  localparam bit          MULTI_FLUSH    = (FLUSH_LEN > 1);
  localparam logic [2:0]  FLUSH_CNT_INIT = 3'(FLUSH_LEN - 2);
  localparam logic [15:0] TIMEOUT_LAST   = STALL_TIMEOUT - 16'd1;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] stall_cnt_q;
  logic        timeout_q;
  logic        stall_hold;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hffff) ? v : v + 16'd1;
  endfunction

  always_comb begin
    jump_en_o    = 1'b0;
    jump_addr_o  = '0;
    hold_pc_o    = 1'b0;
    hold_if_id_o = 1'b0;
    hold_id_ex_o = 1'b0;
    flush_o      = 1'b0;
    stall_hold   = 1'b0;
    state_d      = ST_RUN;
    cnt_d        = cnt_q;
    case (state_q)
      ST_RUN, ST_STALL: begin
        if (jump_en_i) begin
          // A taken jump overrides every hold in the same cycle.
          jump_en_o   = 1'b1;
          jump_addr_o = jump_addr_i;
          flush_o     = 1'b1;
          if (MULTI_FLUSH) begin
            state_d = ST_FLUSH;
            cnt_d   = FLUSH_CNT_INIT;
          end
        end else begin
          hold_pc_o    = hold_flag_ex_i | hold_req_bus_i;
          hold_if_id_o = hold_flag_ex_i | hold_req_bus_i;
          hold_id_ex_o = hold_flag_ex_i;
          stall_hold   = hold_flag_ex_i | hold_req_bus_i;
          state_d      = stall_hold ? ST_STALL : ST_RUN;
        end
      end
      ST_FLUSH: begin
        // Flush dominates: only the PC may be held, and the count keeps running.
        flush_o   = 1'b1;
        hold_pc_o = hold_req_bus_i;
        if (cnt_q == 3'd0) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_FLUSH;
          cnt_d   = cnt_q - 3'd1;
        end
      end
      default: begin
        // Illegal encoding: all outputs quiet, recover to RUN.
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Every accepted hold cycle (the one entering STALL included) counts toward
  // the timeout; leaving for RUN or FLUSH restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_hold ? sat_inc16(stall_cnt_q) : 16'd0;
      if (stall_hold && (stall_cnt_q == TIMEOUT_LAST)) timeout_q <= 1'b1;
    end
  end

  assign timeout_o = timeout_q;
  assign state_o   = state_q;

`ifdef PIPE_CTRL_PERF_EN
  pipe_ctrl_perf u_perf (
    .clk          (clk),
    .rst          (rst),
    .stall_inc    (hold_pc_o),
    .flush_inc    (jump_en_o),
    .stall_cycles (stall_cycles_o),
    .flush_events (flush_events_o)
  );
`else
  assign stall_cycles_o = '0;
  assign flush_events_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        hold_flag_ex_i;
  logic        hold_req_bus_i;

  logic        jump_en_o, hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_o, timeout_o;
  logic [31:0] jump_addr_o, stall_cycles_o, flush_events_o;
  logic [1:0]  state_o;

  logic        b_jump_en_o, b_hold_pc_o, b_hold_if_id_o, b_hold_id_ex_o, b_flush_o, b_timeout_o;
  logic [31:0] b_jump_addr_o, b_stall_cycles_o, b_flush_events_o;
  logic [1:0]  b_state_o;

  int passed = 0;
  int total  = 0;

`ifdef PIPE_CTRL_PERF_EN
  localparam logic [31:0] EXP_FLUSH_EV = 32'd3;
  localparam logic [31:0] EXP_STALL_CY = 32'd5;
`else
  localparam logic [31:0] EXP_FLUSH_EV = 32'd0;
  localparam logic [31:0] EXP_STALL_CY = 32'd0;
`endif

  always #5 clk = ~clk;

  // Main DUT: default FLUSH_LEN=2, STALL_TIMEOUT=1000
  pipe_ctrl #(.FLUSH_LEN(2), .STALL_TIMEOUT(16'd1000)) u_dut (
    .clk(clk), .rst(rst), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .hold_flag_ex_i(hold_flag_ex_i), .hold_req_bus_i(hold_req_bus_i),
    .jump_en_o(jump_en_o), .jump_addr_o(jump_addr_o), .hold_pc_o(hold_pc_o),
    .hold_if_id_o(hold_if_id_o), .hold_id_ex_o(hold_id_ex_o), .flush_o(flush_o),
    .timeout_o(timeout_o), .state_o(state_o),
    .stall_cycles_o(stall_cycles_o), .flush_events_o(flush_events_o));

  // Second DUT: FLUSH_LEN=4, short timeout of 3
  pipe_ctrl #(.FLUSH_LEN(4), .STALL_TIMEOUT(16'd3)) u_dut4 (
    .clk(clk), .rst(rst), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .hold_flag_ex_i(hold_flag_ex_i), .hold_req_bus_i(hold_req_bus_i),
    .jump_en_o(b_jump_en_o), .jump_addr_o(b_jump_addr_o), .hold_pc_o(b_hold_pc_o),
    .hold_if_id_o(b_hold_if_id_o), .hold_id_ex_o(b_hold_id_ex_o), .flush_o(b_flush_o),
    .timeout_o(b_timeout_o), .state_o(b_state_o),
    .stall_cycles_o(b_stall_cycles_o), .flush_events_o(b_flush_events_o));

  typedef struct packed {
    logic        jmp;
    logic [31:0] addr;
    logic        hex;
    logic        hbus;
    logic        e_jmp;
    logic [31:0] e_addr;
    logic        e_pc;
    logic        e_ifid;
    logic        e_idex;
    logic        e_flush;
    logic [1:0]  e_state;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    else passed++;
  endtask

  task automatic drive(input logic j, input logic [31:0] a, input logic hx, input logic hb);
    jump_en_i      = j;
    jump_addr_i    = a;
    hold_flag_ex_i = hx;
    hold_req_bus_i = hb;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    adv();
    rst = 1'b0;
  endtask

  initial begin
    int early;
    logic       exp_fl [5];
    logic [1:0] exp_st [5];

    //           jmp addr          hex hbus  e_jmp e_addr       pc ifid idex flush state
    vecs[0]  = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[1]  = '{1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
    vecs[2]  = '{1'b1, 32'h200, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b1, 2'd1};
    vecs[3]  = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[4]  = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 1'b0, 2'd0};
    vecs[5]  = '{1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 1'b0, 2'd2};
    vecs[6]  = '{1'b1, 32'h300, 1'b0, 1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2};
    vecs[7]  = '{1'b0, 32'h55,  1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b1, 2'd1};
    vecs[8]  = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[9]  = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 1'b0, 2'd0};
    vecs[10] = '{1'b0, 32'h77,  1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 2'd2};
    vecs[11] = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 2'd0};

    // Reset: while rst is high the outputs follow RUN rules on live inputs
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    adv();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    settle();
    chk("rst_run_rules", 64'({hold_pc_o, hold_if_id_o, hold_id_ex_o, state_o}), 64'({3'b111, 2'd0}));
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    adv();
    rst = 1'b0;
    settle();
    chk("reset_state", 64'({jump_en_o, jump_addr_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
                            flush_o, timeout_o, state_o}), 64'd0);
    chk("reset_perf", {stall_cycles_o, flush_events_o}, 64'd0);
    adv();

    // Table-driven single-cycle behaviour on the FLUSH_LEN=2 DUT
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].jmp, vecs[i].addr, vecs[i].hex, vecs[i].hbus);
      settle();
      chk($sformatf("vec%0d", i),
          64'({jump_en_o, jump_addr_o, hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_o, state_o}),
          64'({vecs[i].e_jmp, vecs[i].e_addr, vecs[i].e_pc, vecs[i].e_ifid, vecs[i].e_idex,
               vecs[i].e_flush, vecs[i].e_state}));
      adv();
    end

    // Stall timeout: hold for 1000 cycles, flag rises on cycle 1001
    do_reset();
    early = 0;
    for (int i = 1; i <= 1000; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      settle();
      if (timeout_o !== 1'b0) early++;
      if (i == 3) chk("short_timeout_before", 64'(b_timeout_o), 64'd0);
      if (i == 4) chk("short_timeout_after", 64'(b_timeout_o), 64'd1);
      adv();
    end
    chk("no_early_timeout", 64'(early), 64'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    settle();
    chk("timeout_rise", 64'({timeout_o, state_o, hold_pc_o}), 64'({1'b1, 2'd2, 1'b0}));
    adv();
    for (int i = 0; i < 3; i++) adv();
    settle();
    chk("timeout_sticky", 64'({timeout_o, state_o}), 64'({1'b1, 2'd0}));
    adv();
    do_reset();
    settle();
    chk("timeout_cleared_by_rst", 64'({timeout_o, b_timeout_o}), 64'd0);
    adv();

    // FLUSH_LEN=4: flush high for 4 cycles starting at the jump
    exp_fl = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_st = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
    for (int k = 0; k < 5; k++) begin
      drive(k == 0, (k == 0) ? 32'h40 : 32'h0, 1'b0, 1'b0);
      settle();
      chk($sformatf("flush4_c%0d", k), 64'({b_flush_o, b_state_o}), 64'({exp_fl[k], exp_st[k]}));
      adv();
    end

    // Reset in the middle of a FLUSH_LEN=4 flush
    drive(1'b1, 32'h80, 1'b0, 1'b0);
    settle();
    chk("mid_flush_jump", 64'({b_jump_en_o, b_jump_addr_o}), 64'({1'b1, 32'h80}));
    adv();
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    settle();
    chk("mid_flush_before_rst", 64'({b_flush_o, b_state_o}), 64'({1'b1, 2'd1}));
    adv();
    rst = 1'b0;
    settle();
    chk("mid_flush_after_rst", 64'({b_flush_o, b_state_o, b_jump_en_o}), 64'd0);
    adv();

    // Perf counters: 3 jumps, 5 hold cycles
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      drive((c == 1) || (c == 3) || (c == 5), 32'(c * 16), (c >= 7) && (c <= 11), 1'b0);
      adv();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    settle();
    chk("perf_flush_events", flush_events_o, 64'(EXP_FLUSH_EV));
    chk("perf_stall_cycles", stall_cycles_o, 64'(EXP_STALL_CY));
    adv();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
